// File: rtl/ram_loader_pkg.sv
// Shared constants for the firmware byte loader: FSM encodings, stream framing
// sizes, and the big-endian byte packer.
package ram_loader_pkg;

    localparam logic [2:0] ST_HDR  = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_CSUM = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    localparam int HDR_BYTES     = 4;
    localparam int TRAILER_BYTES = 4;

    // The first byte of a field ends up in bits 31:24.
    function automatic logic [31:0] pack_byte(input logic [31:0] acc, input logic [7:0] b);
        return {acc[23:0], b};
    endfunction

endpackage

// File: rtl/fw_byte_loader.sv
// Streams a length-prefixed, checksummed firmware image into RAM one 32-bit
// word at a time, then releases the CPU or flags an error.
module fw_byte_loader
    import ram_loader_pkg::*;
#(
    parameter int AWIDTH   = 15,
    parameter int RAM_SIZE = 16384
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [7:0]        dat_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [AWIDTH-1:0] ram_loader_adr_o,
    output logic [31:0]       ram_loader_dat_o,
    output logic [3:0]        ram_loader_sel_o,
    output logic              ram_loader_stb_o,
    output logic              ram_loader_we_o,
    output logic              ram_loader_done_o,
    output logic              error_o
);

    localparam int          CW        = AWIDTH - 1;
    localparam logic [31:0] MAX_WORDS = 32'(RAM_SIZE / 4);

    logic [2:0]        state;
    logic [1:0]        byte_cnt;
    logic [31:0]       asm_reg;
    logic [CW-1:0]     word_cnt;
    logic [CW-1:0]     n_words;
    logic [31:0]       sum;
    logic              stb;
    logic [AWIDTH-1:0] adr;
    logic [31:0]       wdat;

    logic              accept;
    logic [31:0]       word_next;
    logic [31:0]       sum_now;
    logic              active;

    assign active    = (state == ST_HDR) || (state == ST_LOAD) || (state == ST_CSUM);
    assign ready_o   = !wb_rst_i && active;
    assign accept    = valid_i && ready_o;
    assign word_next = pack_byte(asm_reg, dat_i);
    // A write pulse still in flight has not been folded into sum yet.
    assign sum_now   = sum + (stb ? wdat : 32'd0);

    assign ram_loader_adr_o  = wb_rst_i ? '0 : adr;
    assign ram_loader_dat_o  = wb_rst_i ? '0 : wdat;
    assign ram_loader_sel_o  = wb_rst_i ? 4'h0 : 4'hF;
    assign ram_loader_stb_o  = !wb_rst_i && stb;
    assign ram_loader_we_o   = !wb_rst_i && stb;
    assign ram_loader_done_o = !wb_rst_i && (state == ST_DONE);
    assign error_o           = !wb_rst_i && (state == ST_ERR);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= ST_HDR;
            byte_cnt <= 2'd0;
            asm_reg  <= 32'd0;
            word_cnt <= '0;
            n_words  <= '0;
            sum      <= 32'd0;
            stb      <= 1'b0;
            adr      <= '0;
            wdat     <= 32'd0;
        end else begin
            stb <= 1'b0;
            if (stb) begin
                sum <= sum_now;
            end
            if (accept) begin
                asm_reg  <= word_next;
                byte_cnt <= byte_cnt + 2'd1;
            end
            case (state)
                ST_HDR: begin
                    if (accept && byte_cnt == 2'(HDR_BYTES - 1)) begin
                        // Range-check the full 32-bit count before narrowing it.
                        if (word_next != 32'd0 && word_next <= MAX_WORDS) begin
                            n_words  <= CW'(word_next);
                            word_cnt <= '0;
                            state    <= ST_LOAD;
                        end else begin
                            state <= ST_ERR;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept && byte_cnt == 2'd3) begin
                        stb      <= 1'b1;
                        adr      <= AWIDTH'({word_cnt, 2'b00});
                        wdat     <= word_next;
                        word_cnt <= word_cnt + CW'(1);
                        if (word_cnt == n_words - CW'(1)) begin
                            state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept && byte_cnt == 2'(TRAILER_BYTES - 1)) begin
                        state <= (word_next == sum_now) ? ST_DONE : ST_ERR;
                    end
                end
                ST_DONE: state <= ST_DONE;
                default: state <= ST_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_fw_byte_loader.sv
// Scoreboard bench for fw_byte_loader: directed streams push expected RAM
// writes, a monitor pops and compares each write strobe.
module tb_fw_byte_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  dat = 8'd0;
    logic        valid = 1'b0;
    logic        ready;
    logic [14:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        stb;
    logic        we;
    logic        done;
    logic        err;

    int n_cmp    = 0;
    int n_bad    = 0;
    int n_writes = 0;
    int stalls   = 0;
    bit aborted  = 1'b0;

    logic [46:0] exp_q[$];

    always #5 clk = ~clk;

    fw_byte_loader dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (rst),
        .dat_i            (dat),
        .valid_i          (valid),
        .ready_o          (ready),
        .ram_loader_adr_o (adr),
        .ram_loader_dat_o (wdat),
        .ram_loader_sel_o (sel),
        .ram_loader_stb_o (stb),
        .ram_loader_we_o  (we),
        .ram_loader_done_o(done),
        .error_o          (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(posedge clk) begin
        #1;
        if (stb === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: adr 0x%0h dat 0x%0h, no write expected", adr, wdat);
            end else begin
                logic [46:0] e;
                e = exp_q.pop_front();
                check("write_adr", 64'(adr), 64'(e[46:32]));
                check("write_dat", 64'(wdat), 64'(e[31:0]));
                check("write_sel", 64'(sel), 64'h0F);
                check("write_we", 64'(we), 64'h1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        if (aborted) return;
        repeat (gap) begin
            @(negedge clk);
            valid = 1'b0;
        end
        @(negedge clk);
        valid = 1'b1;
        dat   = b;
        t     = 0;
        while (ready !== 1'b1 && t < 50) begin
            stalls++;
            t++;
            @(negedge clk);
        end
        if (ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: ready 0x%0h, expected 0x1", ready);
            valid   = 1'b0;
            aborted = 1'b1;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[31 - 8*i -: 8];
            send_byte(b, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        valid   = 1'b0;
        aborted = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_stb", 64'(stb), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(ready), 64'h1);
    endtask

    task automatic image_a(input logic [31:0] trailer, input int gapmax);
        exp_q.push_back({15'h0000, 32'h11223344});
        exp_q.push_back({15'h0004, 32'hAABBCCDD});
        send_word(32'h00000002, gapmax);
        send_word(32'h11223344, gapmax);
        send_word(32'hAABBCCDD, gapmax);
        send_word(trailer, gapmax);
        idle();
    endtask

    task automatic check_end(input string tag, input logic exp_done, input logic exp_err);
        repeat (3) @(negedge clk);
        check({tag, "_done"}, 64'(done), 64'(exp_done));
        check({tag, "_err"}, 64'(err), 64'(exp_err));
        check({tag, "_ready"}, 64'(ready), 64'h0);
        check({tag, "_pending"}, 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        int w0;
        logic [31:0] fsum;
        logic [31:0] fw;

        do_reset();

        // Good two-word image.
        image_a(32'hBBDE0021, 0);
        check_end("img_ok", 1'b1, 1'b0);
        check("img_ok_writes", 64'(n_writes), 64'd2);

        // Bytes offered after DONE must not cause writes.
        w0 = n_writes;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            valid = 1'b1;
            dat   = 8'(i * 37);
        end
        idle();
        repeat (2) @(negedge clk);
        check("done_ignore_writes", 64'(n_writes), 64'(w0));
        check("done_hold", 64'(done), 64'h1);

        // Bad trailer.
        do_reset();
        w0 = n_writes;
        image_a(32'h00000000, 0);
        check_end("bad_csum", 1'b0, 1'b1);
        check("bad_csum_writes", 64'(n_writes - w0), 64'd2);

        // Zero-length and oversize headers.
        do_reset();
        w0 = n_writes;
        send_word(32'h00000000, 0);
        @(negedge clk);
        check("hdr0_err", 64'(err), 64'h1);
        check("hdr0_ready", 64'(ready), 64'h0);
        idle();

        do_reset();
        send_word(32'h00001001, 0);
        @(negedge clk);
        check("hdr_big_err", 64'(err), 64'h1);
        check("hdr_big_done", 64'(done), 64'h0);
        idle();
        repeat (2) @(negedge clk);
        check("hdr_bad_writes", 64'(n_writes), 64'(w0));

        // Full-size image at one byte per cycle.
        do_reset();
        w0     = n_writes;
        stalls = 0;
        fsum   = 32'd0;
        for (int k = 0; k < 4096; k++) begin
            fw = 32'h9E3779B9 * 32'(k) + 32'h01234567;
            fsum += fw;
            exp_q.push_back({15'(k * 4), fw});
        end
        send_word(32'd4096, 0);
        for (int k = 0; k < 4096; k++) begin
            fw = 32'h9E3779B9 * 32'(k) + 32'h01234567;
            send_word(fw, 0);
        end
        send_word(fsum, 0);
        idle();
        check_end("full", 1'b1, 1'b0);
        check("full_writes", 64'(n_writes - w0), 64'd4096);
        check("full_stalls", 64'(stalls), 64'd0);

        // Reset in the middle of word 1: only word 0 may be written.
        do_reset();
        w0 = n_writes;
        exp_q.push_back({15'h0000, 32'h11223344});
        send_word(32'h00000002, 0);
        send_word(32'h11223344, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        do_reset();
        repeat (2) @(negedge clk);
        check("abort_writes", 64'(n_writes - w0), 64'd1);
        check("abort_pending", 64'(exp_q.size()), 64'h0);
        image_a(32'hBBDE0021, 0);
        check_end("after_abort", 1'b1, 1'b0);

        // Same good image with random valid gaps.
        do_reset();
        image_a(32'hBBDE0021, 4);
        check_end("gaps", 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
